// File: rtl/mx8_rr_sched.sv
// Round-robin scheduler driving the select lines of a shared 8:1 mux.
// Grants one requester for a burst of burst+1 beats, with one idle cycle between owners.
module mx8_rr_sched #(
  parameter int BURST_W = 4
) (
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic [7:0]         req,
  input  logic [BURST_W-1:0] burst,
  input  logic               beat,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic [7:0]         gnt,
  output logic               busy,
  output logic               last
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  logic       found;
  logic [2:0] win;
  logic [2:0] idx;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Rotating priority scan: first set request at or after ptr wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          sel_d   = win;
          ptr_d   = win + 3'd1;
          cnt_d   = burst;
        end
      end
      OWN: begin
        // Abort and final beat both release; the select lines stay parked.
        if (!req[sel_q] || (beat && cnt_q == '0)) begin
          state_d = IDLE;
        end else if (beat) begin
          cnt_d = cnt_q - BURST_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state_q == OWN) gnt[sel_q] = 1'b1;
  end

  assign busy = (state_q == OWN);
  assign last = (state_q == OWN) && (cnt_q == '0);
  assign s0   = sel_q[0];
  assign s1   = sel_q[1];
  assign s2   = sel_q[2];

endmodule

// File: doc/mx8_rr_sched.md
# mx8_rr_sched

Round-robin scheduler that shares one 8:1 selector (select lines s2..s0) among eight requesters. It grants one requester at a time for a burst of 1..2^BURST_W beats and drives the selector's select lines from registered state. It returns a one-hot grant to the requesters. It sits in front of the 8-way source mux on a shared data path; the consumer of the mux output signals each accepted datum with `beat`.

## Interface
- BURST_W, 4, width of the burst-length input; maximum burst is 2^BURST_W beats.

- sys_clk  in  1  system clock; all state changes on the rising edge.
- resetl  in  1  asynchronous, active-low reset.
- req  in  8  request per source; bit i requests mux input ai. Level, held until served.
- burst  in  BURST_W  beats per grant minus 1; sampled on the grant cycle only.
- beat  in  1  consumer accepted the current mux output this cycle.
- s0  out  1  mux select bit 0 (registered).
- s1  out  1  mux select bit 1 (registered).
- s2  out  1  mux select bit 2 (registered).
- gnt  out  8  one-hot grant; bit {s2,s1,s0} is set while OWN, all zero otherwise.
- busy  out  1  high while in OWN.
- last  out  1  OWN and remaining-beat count = 0; the next beat ends the burst.

## Operation
- State machine has two states:
  - IDLE: gnt = 0; select lines hold their last value (parked).
  - OWN: one requester owns the mux.
- Arbitration in IDLE:
  - Scan starts at index ptr and wraps modulo 8; the first set req bit wins.
  - Winner index w is loaded into {s2,s1,s0}; gnt[w] is set; cnt is loaded with burst; ptr is loaded with (w+1) mod 8; the state moves to OWN.
  - With no req set, the block stays in IDLE and ptr is unchanged.
- In OWN:
  - beat with cnt > 0: cnt decrements.
  - beat with cnt = 0: burst complete; go to IDLE.
  - req[owner] low (abort): go to IDLE regardless of cnt or beat; ptr already points past the owner.
  - Abort and final beat in the same cycle: go to IDLE once (same result).
- beat outside OWN is ignored.
- There is no back-to-back grant: every release spends at least one cycle in IDLE. This turnaround cycle guarantees select lines never change while gnt is asserted.
- Changes on burst after the grant cycle have no effect on the current burst.
- Widths: cnt is BURST_W bits and decrements only when > 0, so it never wraps. ptr is 3 bits and wraps 7 -> 0.
- Reset values: state IDLE; {s2,s1,s0} = 000; gnt = 0; busy = 0; last = 0; cnt = 0; ptr = 0.

## Timing
- Request to grant:
  - req[i] sampled high at edge n while in IDLE and i is the winner.
  - gnt[i], busy and the new select value are valid after edge n (cycle n+1).
- Beats are counted on edges where beat = 1 and the state is OWN. A burst of B = burst+1 beats ends on the edge that samples the B-th beat.
- Release to next grant:
  - gnt drops the cycle after the final beat or abort.
  - The next grant is visible one cycle later.
  - Minimum request-to-grant latency is 1 cycle. Minimum gap between grants is 1 IDLE cycle.
- last is decoded from state and cnt registers with no dependence on req or beat; it is glitch-free with respect to the inputs.
- Asynchronous reset mid-burst:
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After resetl rises, arbitration restarts from ptr = 0.

## Test plan
- Reset, single requester:
  - Stimulus: assert resetl low, release; req = 0x08, burst = 2, beat held high.
  - Required: gnt = 0x08 and {s2,s1,s0} = 011 one cycle after req is sampled; busy stays high for 3 beats; last is high on the 3rd beat; gnt = 0 on the next cycle.
- Round-robin fairness:
  - Stimulus: req = 0xFF held, burst = 0, beat = 1.
  - Required: grant order 0,1,2,...,7,0; exactly one IDLE cycle between grants; select lines are stable whenever gnt ≠ 0.
- Wrap and skip:
  - Stimulus: ptr = 6 after a grant to source 5; req = 0x81.
  - Required: grant to source 7 first, then source 0.
- Abort:
  - Stimulus: grant to source 2 with burst = 7; drop req[2] after 3 beats.
  - Required: gnt = 0 the next cycle; the next grant goes to the lowest set index ≥ 3 (wrapping).
- Beat gating:
  - Stimulus: beat = 1 while in IDLE; beat = 0 for 5 cycles while in OWN.
  - Required: no state change in IDLE; cnt and gnt hold throughout the stalled OWN cycles.
- Async reset mid-burst:
  - Stimulus: drive resetl low between clock edges during OWN of source 4.
  - Required: gnt = 0, select = 000, busy = 0 immediately, before the next edge; the first grant after reset release goes to the lowest set req index.
